stopwatch_bcd: RTL

Seconds/minutes BCD stopwatch driven by the slow square wave from the upstream clock divider. The block synchronizes that square wave into the `clk` domain and converts each rising edge into a one-cycle tick. A start/stop/clear state machine gates the ticks into a cascaded MM:SS BCD counter. The four digit outputs feed the seven-segment multiplexer downstream.

---
 rtl/stopwatch_pkg.sv | 23 ++
 rtl/sync_edge_detect.sv | 38 +++
 rtl/stopwatch_bcd.sv | 138 +++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS BCD stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t min_tens;
        bcd_t min_ones;
        bcd_t sec_tens;
        bcd_t sec_ones;
    } mmss_t;

    localparam bcd_t SEC_ONES_MAX = 4'd9;
    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t BCD_DIGIT_MAX = 4'd9;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes the slow square wave into clk and emits a one-cycle tick per rise.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic slow_in,
    output logic tick
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_edge;
    logic [SYNC_STAGES:0]   vld_pipe;
    logic                   r_armed;
    logic                   r_tick;

    // vld_pipe marks when r_edge[0] holds a real sample; r_armed waits for a
    // genuine low so a level already high at reset release is not a rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync   <= '0;
            r_edge   <= '0;
            vld_pipe <= '0;
            r_armed  <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], slow_in};
            r_edge   <= {r_edge[0], r_sync[SYNC_STAGES-1]};
            vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
            if (vld_pipe[SYNC_STAGES] && !r_edge[0])
                r_armed <= 1'b1;
            r_tick   <= r_armed & r_edge[0] & ~r_edge[1];
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch: start/stop/clear FSM gating synchronized ticks into digit counters.
// Optional lap display freeze is built when STOPWATCH_LAP_EN is defined.
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_MINUTES = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       slow_in,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       rollover,
    output logic       lap_active
);

    localparam bcd_t MIN_TENS_MAX = bcd_t'(MAX_MINUTES / 10);
    localparam bcd_t MIN_ONES_MAX = bcd_t'(MAX_MINUTES % 10);

    logic   w_tick;
    logic   w_count;
    logic   w_so_wrap;
    logic   w_sec_wrap;
    logic   w_mo_wrap;
    logic   w_min_wrap;
    mmss_t  w_disp;
    state_t r_state;
    logic   r_running;
    logic   r_rollover;
    mmss_t  r_cnt;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .slow_in(slow_in),
        .tick   (w_tick)
    );

    assign w_count    = w_tick && (r_state == ST_RUN) && !clear;
    assign w_so_wrap  = (r_cnt.sec_ones == SEC_ONES_MAX);
    assign w_sec_wrap = w_so_wrap && (r_cnt.sec_tens == SEC_TENS_MAX);
    assign w_mo_wrap  = (r_cnt.min_ones == BCD_DIGIT_MAX);
    assign w_min_wrap = (r_cnt.min_tens == MIN_TENS_MAX) && (r_cnt.min_ones == MIN_ONES_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
        end else if (clear) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
        end else if (start_stop) begin
            case (r_state)
                ST_IDLE:  begin r_state <= ST_RUN;   r_running <= 1'b1; end
                ST_RUN:   begin r_state <= ST_PAUSE; r_running <= 1'b0; end
                ST_PAUSE: begin r_state <= ST_RUN;   r_running <= 1'b1; end
                default:  begin r_state <= ST_IDLE;  r_running <= 1'b0; end
            endcase
        end
    end

    // Each digit carries into the next only at its own terminal value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_rollover <= 1'b0;
        end else begin
            r_rollover <= w_count && w_sec_wrap && w_min_wrap;
            if (clear) begin
                r_cnt <= '0;
            end else if (w_count) begin
                if (!w_so_wrap) begin
                    r_cnt.sec_ones <= r_cnt.sec_ones + 4'd1;
                end else begin
                    r_cnt.sec_ones <= '0;
                    if (!w_sec_wrap) begin
                        r_cnt.sec_tens <= r_cnt.sec_tens + 4'd1;
                    end else begin
                        r_cnt.sec_tens <= '0;
                        if (w_min_wrap) begin
                            r_cnt.min_ones <= '0;
                            r_cnt.min_tens <= '0;
                        end else if (w_mo_wrap) begin
                            r_cnt.min_ones <= '0;
                            r_cnt.min_tens <= r_cnt.min_tens + 4'd1;
                        end else begin
                            r_cnt.min_ones <= r_cnt.min_ones + 4'd1;
                        end
                    end
                end
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic  r_lap_active;
    mmss_t r_cap;

    // Capture the pre-update count on the freeze edge; counting continues underneath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lap_active <= 1'b0;
            r_cap        <= '0;
        end else if (clear) begin
            r_lap_active <= 1'b0;
        end else if (lap && (r_state == ST_RUN)) begin
            r_lap_active <= !r_lap_active;
            if (!r_lap_active)
                r_cap <= r_cnt;
        end
    end

    assign w_disp     = r_lap_active ? r_cap : r_cnt;
    assign lap_active = r_lap_active;
`else
    logic w_unused_lap;
    assign w_unused_lap = lap;
    assign w_disp       = r_cnt;
    assign lap_active   = 1'b0;
`endif

    assign sec_ones = w_disp.sec_ones;
    assign sec_tens = w_disp.sec_tens;
    assign min_ones = w_disp.min_ones;
    assign min_tens = w_disp.min_tens;
    assign running  = r_running;
    assign rollover = r_rollover;

endmodule
